instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction-buffer entries; legal values 2, 4, 8.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous, active-high.
- redirect, in, 1, core took a branch or jump; one-cycle pulse.
- redirect_pc, in, 32, new fetch target.
- instr_ready, in, 1, core accepts the head entry this cycle.
- instruction, out, 32, head instruction word.
- instr_pc, out, 32, address of the head instruction.
- instr_valid, out, 1, head entry valid.
- mem_addr, out, 32, memory read address.
- mem_read, out, 1, memory read request.
- mem_busy, in, 1, memory not done; mem_rdata is valid in any cycle where mem_read=1 and mem_busy=0.
- mem_rdata, in, 32, memory read data.

Function
REQ-003 Fetch addresses SHALL be word-aligned: redirect_pc[1:0] is forced to 2'b00, the fetch pc advances by 4 per completed fetch, and 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-004 The FSM SHALL have exactly three states: FETCH, STALL and DISCARD.
REQ-005 In FETCH with buffer count < DEPTH, the block SHALL drive mem_read=1 and mem_addr=fetch pc.
REQ-006 While mem_busy=1, mem_read and mem_addr SHALL be held stable.
REQ-007 A completion (mem_read=1, mem_busy=0) SHALL push {fetch pc, mem_rdata} into the buffer at that edge, and instr_valid SHALL be 1 in the following cycle; fetch-to-valid latency is 1 cycle after completion.
REQ-008 At most one memory request SHALL be outstanding, and a new request MAY start the cycle after a completion.
REQ-009 FETCH SHALL go to STALL when count==DEPTH; in STALL mem_read=0.
REQ-010 STALL SHALL return to FETCH on the edge where a pop occurs.
REQ-011 A pop SHALL occur when instr_valid=1 and instr_ready=1; instr_ready with instr_valid=0 SHALL have no effect.
REQ-012 A simultaneous push and pop SHALL leave count unchanged and preserve order; the buffer is FIFO.
REQ-013 instruction, instr_pc and instr_valid SHALL come only from buffer head registers, never combinationally from mem_rdata.
REQ-014 Redirect handling SHALL take priority over push and pop. On a redirect edge:
- the buffer empties and instr_valid is 0 next cycle;
- fetch pc is set to redirect_pc;
- data arriving that cycle is dropped.
REQ-015 A redirect while a request is outstanding and mem_busy=1 SHALL enter DISCARD: the request is held until mem_busy=0, the data is dropped, and the next state is FETCH at the redirect target.
REQ-016 A redirect received while in DISCARD SHALL overwrite the target and remain in DISCARD.
REQ-017 A redirect received in STALL SHALL go to FETCH.
REQ-018 instr_valid SHALL never be 1 for an entry fetched before the most recent redirect.

Reset
REQ-019 While rst=1 at an edge, the block SHALL set:
- state FETCH, fetch pc RESET_PC, buffer count 0;
- instr_valid=0, mem_read=0, instruction=0, instr_pc=0, mem_addr=RESET_PC.
REQ-020 mem_read SHALL first assert in the cycle after rst deasserts.
REQ-021 rst mid-request SHALL abandon the request without DISCARD; the memory tolerates a dropped request.
REQ-022 rst SHALL override redirect.

Configuration
REQ-023 With macro FETCH_PERF_EN defined, the block SHALL add these output ports, both cleared by rst:
- fetch_count [31:0], counts pops, wraps.
- flush_count [15:0], counts redirects, saturates at 16'hFFFF.
REQ-024 Without FETCH_PERF_EN, those ports and their counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset release, mem_busy=0, instr_ready=1: mem_addr 0x0, 0x4, 0x8 on consecutive requests; instr_pc follows one cycle after each completion.
- DEPTH=2, instr_ready=0, mem_rdata=32'h3e800093 then 32'h83000113: two pushes, then STALL, mem_read=0; a single pop restarts fetch at 0x8.
- Redirect to 32'h0000_03EA while mem_busy=1 for 3 more cycles: DISCARD, data dropped, next mem_addr=32'h0000_03E8, no stale instr_valid.
- Redirect and pop in the same cycle with a full buffer: buffer empty next cycle, fetch_count +1 (FETCH_PERF_EN), next fetch at the redirect target.
- RESET_PC=32'hFFFF_FFF8: fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted while mem_busy=1: next cycle mem_read=0, instr_valid=0, counters 0.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch front end. It issues word-aligned reads to a
// single-outstanding-request memory and queues the returned words in a small
// in-order buffer. The core consumes the buffer with a valid/ready handshake.
// Redirects (taken branch or jump) flush the buffer and retarget the fetch pc.
// A redirect that lands while a read is still in flight parks the FSM in
// DISCARD until that read retires, and the read's data is dropped.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   DEPTH       instruction-buffer entries (2, 4 or 8)
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous, active-high reset
//   redirect     one-cycle pulse: the core took a branch or jump
//   redirect_pc  new fetch target (bits [1:0] are ignored)
//   instr_ready  core accepts the head entry this cycle
//   instruction  head instruction word
//   instr_pc     address of the head instruction
//   instr_valid  head entry valid
//   mem_addr     memory read address
//   mem_read     memory read request
//   mem_busy     memory not done; data is valid when mem_read & ~mem_busy
//   mem_rdata    memory read data
//
// Optional build macro FETCH_PERF_EN adds two counter outputs:
//   fetch_count  [31:0] number of pops, wraps
//   flush_count  [15:0] number of redirects, saturates at 16'hFFFF
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic        mem_busy,
  input  logic [31:0] mem_rdata
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  // Count needs one extra bit so that "full" (== DEPTH) is representable.
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    STALL   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t               state_reg;
  logic [31:0]          pc_reg;
  logic [31:0]          mem_addr_reg;
  logic                 mem_read_reg;
  logic [CW-1:0]        count_reg;
  logic                 valid_reg;

  // Buffer storage; entry 0 is always the head, so the outputs come straight
  // from registers and a pop is a one-position shift toward entry 0.
  logic [DEPTH-1:0][31:0] buf_pc_reg;
  logic [DEPTH-1:0][31:0] buf_data_reg;
  logic [DEPTH-1:0][31:0] buf_pc_next;
  logic [DEPTH-1:0][31:0] buf_data_next;

  logic                 completion;
  logic                 push;
  logic                 pop;
  logic                 hold_request;
  logic [CW-1:0]        count_next;
  logic [CW-1:0]        wr_idx;
  logic [31:0]          pc_inc;
  logic [31:0]          fetch_pc_next;
  logic [31:0]          redirect_target;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_inc          = pc_reg + 32'd4;

  // A read retires in any cycle the request is up and memory is not busy.
  assign completion   = mem_read_reg & ~mem_busy;
  assign hold_request = mem_read_reg & mem_busy;

  // Only a retiring read issued from FETCH carries live data; in DISCARD the
  // data belongs to a pre-redirect address, and a redirect this cycle drops it.
  assign push = completion & (state_reg == FETCH) & ~redirect;
  assign pop  = valid_reg & instr_ready;

  assign count_next    = count_reg + CW'(push) - CW'(pop);
  assign fetch_pc_next = push ? pc_inc : pc_reg;

  // When a pop and a push coincide the new word lands one slot lower,
  // behind the surviving entries after the shift.
  assign wr_idx = count_reg - CW'(pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] shift_pc;
      logic [31:0] shift_data;

      if (gi < DEPTH - 1) begin : g_mid
        assign shift_pc   = pop ? buf_pc_reg[gi+1]   : buf_pc_reg[gi];
        assign shift_data = pop ? buf_data_reg[gi+1] : buf_data_reg[gi];
      end else begin : g_last
        assign shift_pc   = buf_pc_reg[gi];
        assign shift_data = buf_data_reg[gi];
      end

      assign buf_pc_next[gi]   = (push && (wr_idx == CW'(gi))) ? pc_reg    : shift_pc;
      assign buf_data_next[gi] = (push && (wr_idx == CW'(gi))) ? mem_rdata : shift_data;
    end
  endgenerate

  // Entries beyond count are don't-care; a redirect only clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_pc_reg   <= '0;
      buf_data_reg <= '0;
    end else begin
      buf_pc_reg   <= buf_pc_next;
      buf_data_reg <= buf_data_next;
    end
  end

  // Control FSM. mem_read/mem_addr are registered: the value chosen at an
  // edge is what memory sees for the whole following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Any in-flight request is simply abandoned; no DISCARD after reset.
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      mem_addr_reg <= RESET_PC;
      mem_read_reg <= 1'b0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
    end else if (redirect) begin
      count_reg <= '0;
      valid_reg <= 1'b0;
      pc_reg    <= redirect_target;
      if (hold_request) begin
        // The old request must stay on the bus until memory finishes;
        // its data will be thrown away. Also covers redirect in DISCARD.
        state_reg <= DISCARD;
      end else begin
        // Nothing in flight (or it retires now and is dropped): restart
        // immediately at the new target on an empty buffer.
        state_reg    <= FETCH;
        mem_read_reg <= 1'b1;
        mem_addr_reg <= redirect_target;
      end
    end else begin
      count_reg <= count_next;
      valid_reg <= (count_next != '0);
      pc_reg    <= fetch_pc_next;
      case (state_reg)
        FETCH: begin
          if (hold_request) begin
            state_reg <= FETCH;
          end else if (count_next < DEPTH_C) begin
            state_reg    <= FETCH;
            mem_read_reg <= 1'b1;
            mem_addr_reg <= fetch_pc_next;
          end else begin
            // Buffer full: stop requesting until the core drains an entry.
            state_reg    <= STALL;
            mem_read_reg <= 1'b0;
            mem_addr_reg <= fetch_pc_next;
          end
        end
        STALL: begin
          if (pop) begin
            state_reg    <= FETCH;
            mem_read_reg <= 1'b1;
            mem_addr_reg <= pc_reg;
          end
        end
        DISCARD: begin
          if (!mem_busy) begin
            // Stale read retired; pc_reg already holds the redirect target.
            state_reg    <= FETCH;
            mem_read_reg <= 1'b1;
            mem_addr_reg <= pc_reg;
          end
        end
        default: begin
          state_reg    <= FETCH;
          mem_read_reg <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = buf_data_reg[0];
  assign instr_pc    = buf_pc_reg[0];
  assign instr_valid = valid_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_read    = mem_read_reg;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_reg;
  logic [15:0] flush_count_reg;

  // A pop in the same cycle as a redirect still delivered an instruction,
  // so it is counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (pop) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end
      if (redirect && (flush_count_reg != 16'hFFFF)) begin
        flush_count_reg <= flush_count_reg + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_count_reg;
  assign flush_count = flush_count_reg;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch (DEPTH=2). A second instance with RESET_PC near the
// top of the address space shares the stimulus to exercise pc wrap-around.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        mem_busy;
  logic [31:0] mem_rdata;

  logic [31:0] instruction, instr_pc, mem_addr;
  logic        instr_valid, mem_read;
  logic [31:0] instruction2, instr_pc2, mem_addr2;
  logic        instr_valid2, mem_read2;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, fetch_count2;
  logic [15:0] flush_count, flush_count2;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .flush_count(flush_count)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_ready(instr_ready), .instruction(instruction2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .mem_addr(mem_addr2), .mem_read(mem_read2),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count2), .flush_count(flush_count2)
`endif
  );

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        busy;
    logic [31:0] rdata;
    logic        e_mr;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0;
    instr_ready = 1'b0; mem_busy = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Memory contents as a pure function of address.
  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Random-phase reference state (stream-level view of the fetch unit).
  logic [31:0] exp_fetch;   // address the next accepted completion must carry
  logic [31:0] exp_pc;      // pc of the next instruction handed to the core
  int          occ;         // accepted-but-not-consumed instructions
  bit          pend;        // an in-flight read is known to be stale
  bit          hold_prev;
  logic [31:0] prev_addr;
  int          rand_pops;
  int          rand_redirs;
`ifdef FETCH_PERF_EN
  logic [31:0] fc_save;
  logic [15:0] fl_save;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst redir rpc rdy busy rdata | mr addr valid pc instr
    vecs[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1111_1111,  1'b1, 32'h4, 1'b1, 32'h0, 32'h1111_1111};
    vecs[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2222_2222,  1'b1, 32'h8, 1'b1, 32'h4, 32'h2222_2222};
    vecs[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h3333_3333,  1'b1, 32'hC, 1'b1, 32'h8, 32'h3333_3333};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3e80_0093,  1'b1, 32'h4, 1'b1, 32'h0, 32'h3e80_0093};
    vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8300_0113,  1'b0, 32'h0, 1'b1, 32'h0, 32'h3e80_0093};
    vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,          1'b0, 32'h0, 1'b1, 32'h0, 32'h3e80_0093};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,          1'b1, 32'h8, 1'b1, 32'h4, 32'h8300_0113};
    vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,          1'b1, 32'h8, 1'b1, 32'h4, 32'h8300_0113};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // ---------------- table-driven: sequential fetch and stall ----------------
    for (int i = 0; i < 12; i++) begin
      rst = vecs[i].rst; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      instr_ready = vecs[i].rdy; mem_busy = vecs[i].busy; mem_rdata = vecs[i].rdata;
      tick();
      $display("[TB] vec %0d: mem_read=%0b mem_addr=%h valid=%0b pc=%h instr=%h",
               i, mem_read, mem_addr, instr_valid, instr_pc, instruction);
      chk($sformatf("vec%0d mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].e_mr});
      if (vecs[i].e_mr) chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid || vecs[i].rst) begin
        chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d instruction", i), instruction, vecs[i].e_instr);
      end
`ifdef FETCH_PERF_EN
      if (i == 1) chk("ready_without_valid fetch_count", fetch_count, 32'd0);
`endif
    end

    // ---------------- redirect while busy: DISCARD ----------------
    do_reset();
    tick();                                   // request at 0x0 goes out
    mem_rdata = 32'hAAAA_0001; tick();        // push 0x0, request 0x4
    mem_busy = 1'b1; tick();
    chk("disc pre valid", {31'b0, instr_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_03EA; tick();
    redirect = 1'b0;
    $display("[TB] discard: redirect edge mem_read=%0b mem_addr=%h valid=%0b", mem_read, mem_addr, instr_valid);
    chk("disc redirect valid", {31'b0, instr_valid}, 32'd0);
    chk("disc held mem_read", {31'b0, mem_read}, 32'd1);
    chk("disc held mem_addr", mem_addr, 32'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("disc busy%0d valid", k), {31'b0, instr_valid}, 32'd0);
      chk($sformatf("disc busy%0d mem_addr", k), mem_addr, 32'h4);
    end
    mem_busy = 1'b0; mem_rdata = 32'hDEAD_BEEF; tick();
    $display("[TB] discard: release mem_read=%0b mem_addr=%h valid=%0b", mem_read, mem_addr, instr_valid);
    chk("disc drop valid", {31'b0, instr_valid}, 32'd0);
    chk("disc target mem_read", {31'b0, mem_read}, 32'd1);
    chk("disc target mem_addr", mem_addr, 32'h0000_03E8);
    mem_rdata = 32'hCAFE_0001; tick();
    chk("disc first valid", {31'b0, instr_valid}, 32'd1);
    chk("disc first pc", instr_pc, 32'h0000_03E8);
    chk("disc first instr", instruction, 32'hCAFE_0001);

    // ---------------- redirect + pop with full buffer ----------------
    do_reset();
    tick(); mem_rdata = 32'h0000_0A01; tick(); mem_rdata = 32'h0000_0A02; tick();
    chk("full mem_read", {31'b0, mem_read}, 32'd0);
`ifdef FETCH_PERF_EN
    fc_save = fetch_count; fl_save = flush_count;
`endif
    redirect = 1'b1; redirect_pc = 32'h0000_0100; instr_ready = 1'b1; tick();
    redirect = 1'b0; instr_ready = 1'b0;
    $display("[TB] redirect+pop: valid=%0b mem_read=%0b mem_addr=%h", instr_valid, mem_read, mem_addr);
    chk("rpop valid", {31'b0, instr_valid}, 32'd0);
    chk("rpop mem_read", {31'b0, mem_read}, 32'd1);
    chk("rpop mem_addr", mem_addr, 32'h0000_0100);
`ifdef FETCH_PERF_EN
    chk("rpop fetch_count", fetch_count, fc_save + 32'd1);
    chk("rpop flush_count", {16'b0, flush_count}, {16'b0, fl_save + 16'd1});
`endif
    mem_rdata = 32'h0000_0005; tick();
    chk("rpop next pc", instr_pc, 32'h0000_0100);
    chk("rpop next instr", instruction, 32'h0000_0005);

    // ---------------- pc wrap with RESET_PC = 0xFFFFFFF8 ----------------
    do_reset();
    instr_ready = 1'b1;
    tick();
    chk("wrap addr0", mem_addr2, 32'hFFFF_FFF8);
    mem_rdata = 32'h0000_00B1; tick();
    chk("wrap addr1", mem_addr2, 32'hFFFF_FFFC);
    chk("wrap pc0", instr_pc2, 32'hFFFF_FFF8);
    mem_rdata = 32'h0000_00B2; tick();
    $display("[TB] wrap: mem_addr2=%h instr_pc2=%h", mem_addr2, instr_pc2);
    chk("wrap addr2", mem_addr2, 32'h0000_0000);
    chk("wrap pc1", instr_pc2, 32'hFFFF_FFFC);
    mem_rdata = 32'h0000_00B3; tick();
    chk("wrap pc2", instr_pc2, 32'h0000_0000);

    // ---------------- reset mid-request ----------------
    do_reset();
    tick(); mem_rdata = 32'h0000_0C01; tick();
    instr_ready = 1'b1; mem_busy = 1'b1; tick();
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_4444; instr_ready = 1'b0; tick();
    $display("[TB] rst mid-request: mem_read=%0b valid=%0b mem_addr=%h", mem_read, instr_valid, mem_addr);
    chk("rst mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst valid", {31'b0, instr_valid}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    chk("rst instruction", instruction, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst fetch_count", fetch_count, 32'd0);
    chk("rst flush_count", {16'b0, flush_count}, 32'd0);
`endif
    rst = 1'b0; redirect = 1'b0; mem_busy = 1'b0; tick();
    chk("post-rst mem_read", {31'b0, mem_read}, 32'd1);
    chk("post-rst mem_addr", mem_addr, 32'h0);

    // ---------------- randomized run vs stream-level reference ----------------
    do_reset();
    exp_fetch = 32'h0; exp_pc = 32'h0; occ = 0; pend = 0; hold_prev = 0;
    prev_addr = '0; rand_pops = 0; rand_redirs = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd valid_vs_occupancy", {31'b0, instr_valid}, {31'b0, (occ > 0)});
      if (hold_prev) begin
        chk("rnd hold mem_read", {31'b0, mem_read}, 32'd1);
        chk("rnd hold mem_addr", mem_addr, prev_addr);
      end
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom();
      instr_ready = ($urandom_range(0, 9) < 6);
      mem_busy    = ($urandom_range(0, 9) < 4);
      mem_rdata   = mem_func(mem_addr);

      if (instr_valid && instr_ready) begin
        if (instr_pc !== exp_pc || instruction !== mem_func(exp_pc))
          $display("[TB] rnd cycle %0d pop: pc=%h instr=%h", cyc, instr_pc, instruction);
        chk("rnd pop pc", instr_pc, exp_pc);
        chk("rnd pop instr", instruction, mem_func(exp_pc));
        exp_pc = exp_pc + 32'd4;
        rand_pops++;
        occ--;
      end
      if (mem_read && !mem_busy) begin
        if (!redirect && !pend) begin
          chk("rnd fetch addr", mem_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
          occ++;
        end
        pend = 0;
      end
      if (redirect) begin
        if (mem_read && mem_busy) pend = 1;
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        occ = 0;
        rand_redirs++;
      end
      if (occ > 2) begin
        tests++; fails++;
        $display("FAIL rnd occupancy: got %0d entries, expected at most 2", occ);
        occ = 2;
      end
      hold_prev = mem_read && mem_busy;
      prev_addr = mem_addr;
      tick();
    end
    $display("[TB] random: %0d pops, %0d redirects", rand_pops, rand_redirs);
    tests++;
    if (rand_pops < 100) begin
      fails++;
      $display("FAIL rnd progress: got %0d pops, expected at least 100", rand_pops);
    end
`ifdef FETCH_PERF_EN
    chk("rnd fetch_count", fetch_count, rand_pops);
    chk("rnd flush_count", {16'b0, flush_count}, rand_redirs);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
